// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the clock time-setting controller:
// FSM states, edit-field display codes and the 6-bit time value type.
package time_set_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SET_HOUR,
      ST_SET_MIN,
      ST_SET_SEC,
      ST_COMMIT
   } state_t;

   typedef logic [5:0] tval_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   localparam int HOUR_MAX_DEF   = 23;
   localparam int MINSEC_MAX_DEF = 59;

   function automatic logic is_set_state(input state_t s);
      return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
   endfunction

   function automatic logic [1:0] field_of(input state_t s);
      case (s)
         ST_SET_HOUR: return FIELD_HOUR;
         ST_SET_MIN:  return FIELD_MIN;
         ST_SET_SEC:  return FIELD_SEC;
         default:     return FIELD_NONE;
      endcase
   endfunction

   // Out-of-range live counter values are not meaningful to edit; start from 0.
   function automatic tval_t clamp_val(input tval_t v, input tval_t max_v);
      return (v > max_v) ? '0 : v;
   endfunction

endpackage

// File: rtl/time_set_ctrl_mod_step.sv
// Combinational wrap-around +1/-1 on a 6-bit value in the range 0..i_max.
module mod_step
   import time_set_pkg::*;
(
   input  tval_t i_val,
   input  tval_t i_max,
   input  logic  i_up,
   output tval_t o_val
);

   always_comb begin
      o_val = i_val;
      if (i_up) begin
         o_val = (i_val >= i_max) ? '0 : i_val + 6'd1;
      end else begin
         o_val = ((i_val == '0) || (i_val > i_max)) ? i_max : i_val - 6'd1;
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: walks hour/minute/second edit fields from button
// pulses, holds the counters stopped while editing and loads them on commit.
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int HOUR_MAX   = HOUR_MAX_DEF,
   parameter int MINSEC_MAX = MINSEC_MAX_DEF,
   parameter int TIMEOUT    = 1000,
   parameter int BLINK_HALF = 25
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  tval_t      count_hour,
   input  tval_t      count_minute,
   input  tval_t      count_second,
   output logic       enable_run,
   output logic       load_hour,
   output logic       load_minute,
   output logic       load_second,
   output tval_t      data_hour,
   output tval_t      data_minute,
   output tval_t      data_second,
   output logic [1:0] edit_field,
   output logic       blink
);

   localparam tval_t HMAX  = tval_t'(HOUR_MAX);
   localparam tval_t MSMAX = tval_t'(MINSEC_MAX);
   localparam int    IDLE_W = $clog2(TIMEOUT + 1);
   localparam int    BLK_W  = $clog2(BLINK_HALF + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_HALF - 1);

   state_t            r_state;
   state_t            w_next;
   tval_t             r_hour;
   tval_t             r_min;
   tval_t             r_sec;
   logic [IDLE_W-1:0] r_idle;
   logic [BLK_W-1:0]  r_bcnt;
   logic              r_blink;
   logic              r_load;
   logic              r_enable;
   logic [1:0]        r_field;

   logic  w_set;
   logic  w_any_btn;
   logic  w_idle_exp;
   logic  w_step_en;
   tval_t w_step_in;
   tval_t w_step_max;
   tval_t w_step_out;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_set      = is_set_state(r_state);
      w_any_btn  = btn_mode | btn_inc | btn_dec;
      w_idle_exp = w_set && !w_any_btn && (r_idle == IDLE_LAST);
      // Mode has priority; inc and dec together cancel but still count as activity.
      w_step_en  = w_set && !btn_mode && (btn_inc ^ btn_dec);
      w_step_in  = r_sec;
      w_step_max = MSMAX;

      case (r_state)
         ST_RUN: begin
            if (btn_mode) w_next = ST_SET_HOUR;
         end
         ST_SET_HOUR: begin
            w_step_in  = r_hour;
            w_step_max = HMAX;
            if (btn_mode)        w_next = ST_SET_MIN;
            else if (w_idle_exp) w_next = ST_RUN;
         end
         ST_SET_MIN: begin
            w_step_in = r_min;
            if (btn_mode)        w_next = ST_SET_SEC;
            else if (w_idle_exp) w_next = ST_RUN;
         end
         ST_SET_SEC: begin
            if (btn_mode)        w_next = ST_COMMIT;
            else if (w_idle_exp) w_next = ST_RUN;
         end
         ST_COMMIT: begin
            w_next = ST_RUN;
         end
         default: begin
            w_next = ST_RUN;
         end
      endcase
   end

   mod_step u_step (
      .i_val (w_step_in),
      .i_max (w_step_max),
      .i_up  (btn_inc),
      .o_val (w_step_out)
   );

   // Registered outputs are derived from the next state so they line up with it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hour   <= '0;
         r_min    <= '0;
         r_sec    <= '0;
         r_idle   <= '0;
         r_bcnt   <= '0;
         r_blink  <= 1'b0;
         r_load   <= 1'b0;
         r_enable <= 1'b1;
         r_field  <= FIELD_NONE;
      end else begin
         r_load   <= (w_next == ST_COMMIT);
         r_enable <= (w_next == ST_RUN);
         r_field  <= field_of(w_next);

         if (!w_set || w_any_btn || w_idle_exp) r_idle <= '0;
         else                                   r_idle <= r_idle + 1'b1;

         if (is_set_state(w_next)) begin
            if (w_next != r_state) begin
               r_blink <= 1'b1;
               r_bcnt  <= '0;
            end else if (r_bcnt == BLK_LAST) begin
               r_blink <= ~r_blink;
               r_bcnt  <= '0;
            end else begin
               r_bcnt  <= r_bcnt + 1'b1;
            end
         end else begin
            r_blink <= 1'b0;
            r_bcnt  <= '0;
         end

         if ((r_state == ST_RUN) && btn_mode) begin
            r_hour <= clamp_val(count_hour, HMAX);
            r_min  <= clamp_val(count_minute, MSMAX);
            r_sec  <= clamp_val(count_second, MSMAX);
         end else if (w_step_en) begin
            case (r_state)
               ST_SET_HOUR: r_hour <= w_step_out;
               ST_SET_MIN:  r_min  <= w_step_out;
               default:     r_sec  <= w_step_out;
            endcase
         end
      end
   end

   assign enable_run  = r_enable;
   assign load_hour   = r_load;
   assign load_minute = r_load;
   assign load_second = r_load;
   assign data_hour   = r_hour;
   assign data_minute = r_min;
   assign data_second = r_sec;
   assign edit_field  = r_field;
   assign blink       = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences; expected commits are
// queued by the stimulus and checked by a monitor on every load strobe.
module tb_time_set_ctrl;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic [5:0] count_hour = 6'd10;
   logic [5:0] count_minute = 6'd20;
   logic [5:0] count_second = 6'd30;
   logic       enable_run;
   logic       load_hour;
   logic       load_minute;
   logic       load_second;
   logic [5:0] data_hour;
   logic [5:0] data_minute;
   logic [5:0] data_second;
   logic [1:0] edit_field;
   logic       blink;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0] h;
      logic [5:0] m;
      logic [5:0] s;
   } exp_t;
   exp_t exp_q[$];

   time_set_ctrl #(
      .HOUR_MAX   (23),
      .MINSEC_MAX (59),
      .TIMEOUT    (20),
      .BLINK_HALF (3)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .btn_dec      (btn_dec),
      .count_hour   (count_hour),
      .count_minute (count_minute),
      .count_second (count_second),
      .enable_run   (enable_run),
      .load_hour    (load_hour),
      .load_minute  (load_minute),
      .load_second  (load_second),
      .data_hour    (data_hour),
      .data_minute  (data_minute),
      .data_second  (data_second),
      .edit_field   (edit_field),
      .blink        (blink)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic m, input logic i, input logic d);
      btn_mode = m;
      btn_inc  = i;
      btn_dec  = d;
      tick();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
   endtask

   task automatic push_commit(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
      exp_t e;
      e.h = h;
      e.m = m;
      e.s = s;
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle with a load strobe must match a queued commit.
   always @(negedge clock) begin
      if (load_hour || load_minute || load_second) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load actual=%0d%0d%0d required=no load",
                     load_hour, load_minute, load_second);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("load_strobes", {29'd0, load_hour, load_minute, load_second}, 32'd7);
            chk("commit_hour", data_hour, e.h);
            chk("commit_minute", data_minute, e.m);
            chk("commit_second", data_second, e.s);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic blink_pat [7];
      blink_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_enable", enable_run, 1);
      chk("rst_loads", {load_hour, load_minute, load_second}, 0);
      chk("rst_data", {data_hour, data_minute, data_second}, 0);
      chk("rst_field", edit_field, 0);
      chk("rst_blink", blink, 0);
      reset_n = 1'b1;
      tick();
      press(0, 1, 0);
      chk("run_ignore_inc", data_hour, 0);

      // Enter and commit from 10:20:30
      press(1, 0, 0);
      chk("t1_enable_off", enable_run, 0);
      chk("t1_field_hour", edit_field, 1);
      chk("t1_snap_hour", data_hour, 10);
      chk("t1_snap_min", data_minute, 20);
      chk("t1_snap_sec", data_second, 30);
      chk("t1_blink_start", blink, 1);
      press(0, 1, 0);
      press(0, 1, 0);
      chk("t1_hour_inc2", data_hour, 12);
      press(1, 0, 0);
      chk("t1_field_min", edit_field, 2);
      press(0, 0, 1);
      chk("t1_min_dec", data_minute, 19);
      press(1, 0, 0);
      chk("t1_field_sec", edit_field, 3);
      chk("t1_enable_sec", enable_run, 0);
      push_commit(12, 19, 30);
      press(1, 0, 0);
      chk("t1_commit_enable", enable_run, 0);
      chk("t1_commit_load", load_hour, 1);
      chk("t1_commit_field", edit_field, 0);
      tick();
      chk("t1_after_enable", enable_run, 1);
      chk("t1_after_load", load_hour, 0);
      chk("t1_hold_hour", data_hour, 12);

      // Wrap boundaries
      count_hour = 6'd23; count_minute = 6'd0; count_second = 6'd5;
      press(1, 0, 0);
      chk("wrap_snap_hour", data_hour, 23);
      press(0, 1, 0);
      chk("wrap_hour_up", data_hour, 0);
      press(0, 0, 1);
      chk("wrap_hour_down", data_hour, 23);
      press(1, 0, 0);
      press(0, 0, 1);
      chk("wrap_min_down", data_minute, 59);
      press(0, 1, 0);
      chk("wrap_min_up", data_minute, 0);
      press(0, 1, 1);
      chk("incdec_min", data_minute, 0);
      press(1, 0, 0);
      push_commit(23, 0, 5);
      press(1, 0, 0);
      tick();

      // Simultaneous buttons then idle timeout in SET_MIN
      count_hour = 6'd5; count_minute = 6'd6; count_second = 6'd7;
      press(1, 0, 0);
      press(0, 1, 1);
      chk("incdec_hour", data_hour, 5);
      press(1, 1, 0);
      chk("modeinc_field", edit_field, 2);
      chk("modeinc_hour", data_hour, 5);
      chk("modeinc_min", data_minute, 6);
      repeat (19) tick();
      chk("idle19_field", edit_field, 2);
      chk("idle19_enable", enable_run, 0);
      tick();
      chk("timeout_field", edit_field, 0);
      chk("timeout_enable", enable_run, 1);
      chk("timeout_blink", blink, 0);
      chk("timeout_hold", data_hour, 5);
      repeat (3) tick();

      // Blink pattern and snapshot clamping
      count_hour = 6'd30; count_minute = 6'd61; count_second = 6'd7;
      press(1, 0, 0);
      chk("clamp_hour", data_hour, 0);
      chk("clamp_min", data_minute, 0);
      chk("clamp_sec", data_second, 7);
      chk("blink_c0", blink, blink_pat[0]);
      for (int k = 1; k < 7; k++) begin
         tick();
         chk($sformatf("blink_c%0d", k), blink, blink_pat[k]);
      end
      press(1, 0, 0);
      chk("blink_restart", blink, 1);
      press(1, 0, 0);
      push_commit(0, 0, 7);
      press(1, 0, 0);
      chk("blink_commit", blink, 0);
      tick();
      chk("blink_run", blink, 0);

      // Reset pulled in SET_SEC
      count_hour = 6'd1; count_minute = 6'd2; count_second = 6'd3;
      press(1, 0, 0);
      press(1, 0, 0);
      press(1, 0, 0);
      chk("pre_rst_field", edit_field, 3);
      reset_n = 1'b0;
      #1;
      chk("midrst_enable", enable_run, 1);
      chk("midrst_field", edit_field, 0);
      chk("midrst_blink", blink, 0);
      chk("midrst_load", {load_hour, load_minute, load_second}, 0);
      chk("midrst_data", {data_hour, data_minute, data_second}, 0);
      tick();
      reset_n = 1'b1;
      repeat (5) tick();
      chk("postrst_enable", enable_run, 1);
      chk("postrst_field", edit_field, 0);

      repeat (3) tick();
      chk("commits_seen", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-setting controller for the digital clock. It turns debounced mode/increment/decrement button pulses into the load interface of the hour, minute and second counters: `load_*` pulses and `data_*` values. While the user is editing, it holds the counters' shared run enable low. It sits between the button debouncers and the counter_hour / counter_minute / counter_second instances, and drives their load, data and enable inputs.

## Interface
Parameters:
- HOUR_MAX, 23: highest hour value; hour edits wrap 0..HOUR_MAX.
- MINSEC_MAX, 59: highest minute/second value; edits wrap 0..MINSEC_MAX.
- TIMEOUT, 1000: idle cycles in any set state before abort (≥2).
- BLINK_HALF, 25: cycles per blink half-period (≥1).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  one-cycle pulse, advance edit field.
- btn_inc  in  1  one-cycle pulse, increment edited field.
- btn_dec  in  1  one-cycle pulse, decrement edited field.
- count_hour  in  6  live hour value from counter_hour.
- count_minute  in  6  live minute value.
- count_second  in  6  live second value.
- enable_run  out  1  counter enable; 0 while editing.
- load_hour, load_minute, load_second  out  1 each  one-cycle load strobes.
- data_hour, data_minute, data_second  out  6 each  values to load.
- edit_field  out  2  0=none, 1=hour, 2=minute, 3=second (display select).
- blink  out  1  square wave for the field being edited; 0 in RUN.

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN + btn_mode: snapshot count_hour/minute/second into edit registers, then go to SET_HOUR.
- SET_HOUR + btn_mode goes to SET_MIN. SET_MIN + btn_mode goes to SET_SEC. SET_SEC + btn_mode goes to COMMIT.
- COMMIT lasts exactly one cycle, then the state returns to RUN.
- In SET_x, btn_inc adds 1 to field x modulo (MAX+1); btn_dec subtracts 1 modulo (MAX+1).
  - The hour field wraps 23 to 0 and 0 to 23.
  - The minute and second fields wrap 59 to 0 and 0 to 59.
- Simultaneous buttons:
  - btn_inc and btn_dec in the same cycle: no change, but the idle timer still clears.
  - btn_mode together with inc/dec: mode wins, and inc/dec are ignored that cycle.
- Idle timer:
  - Clears on any button pulse in a set state.
  - If it reaches TIMEOUT, the state goes to RUN with no load strobe. The counters resume from their un-edited values.
- In RUN, button pulses other than btn_mode are ignored.
- A snapshot input value above MAX is clamped to 0 at capture.

## Timing
- Reset values:
  - state RUN; enable_run=1.
  - all load_*=0; all data_*=0.
  - edit_field=0; blink=0; idle and blink counters at 0.
- All outputs are registered, with no combinational input-to-output path.
- The state, edit_field and enable_run change on the edge after the qualifying button cycle.
- enable_run:
  - Drops to 0 the first cycle of SET_HOUR.
  - Stays 0 through COMMIT.
  - Returns to 1 the cycle after COMMIT.
- In COMMIT:
  - load_hour, load_minute and load_second are all 1 for exactly that one cycle.
  - data_* carry the edit registers in the same cycle.
  - No other cycle asserts a load strobe.
- data_* track the edit registers continuously while editing. They hold their last value in RUN.
- Edit-register updates become visible on data_* one cycle after the button pulse.
- blink toggles every BLINK_HALF cycles in set states. It restarts at 1 on each field change and forces 0 in RUN/COMMIT.
- Reset asserted mid-edit: return to RUN immediately, with no load and enable_run=1.

## Structure
- Package time_set_pkg holds:
  - the state enum;
  - the edit_field encodings FIELD_NONE/HOUR/MIN/SEC;
  - the default HOUR_MAX/MINSEC_MAX constants;
  - the 6-bit time-value typedef.
- Sub-module mod_step: 6-bit combinational wrap-around increment/decrement with a max input. It is instantiated once and muxed by the active field.
- FSM, idle counter, blink counter and edit registers live in time_set_ctrl.

## Test plan
- Enter and commit: with counters at 10:20:30, mode, inc ×2, mode, dec, mode, mode.
  - load_* pulse once, with data 12/19/30.
  - enable_run is 0 from the first mode until the cycle after COMMIT.
- Wrap: edit hour 23 with inc → 0, then dec → 23. Edit minute 0 with dec → 59, then inc → 0.
- Simultaneous: inc+dec in one cycle → value unchanged. mode+inc in SET_HOUR → SET_MIN with hour unchanged.
- Timeout: with TIMEOUT=20, enter SET_MIN and idle 20 cycles → state RUN, no load strobe, enable_run=1.
- Reset mid-edit: pull reset_n low in SET_SEC → all outputs at reset values within the same cycle, and no load after release.
- Blink: with BLINK_HALF=3 in SET_HOUR, blink is 1,1,1,0,0,0,1… on consecutive cycles, and 0 in RUN.
